// File: rtl/locker_controller.sv
`timescale 1ns/1ps
// Keypad locker controller: 4-digit BCD code entry, timed unlock, fail and lockout.
// Optional build macro PWD_CHANGE_EN adds the SET state for changing the password from OPEN.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for the first digit, buffer empty
// ENTRY  | collecting up to four digits, '*' aborts, '#' submits
// CHECK  | one-cycle compare of the buffer against the password
// OPEN   | unlocked for UNLOCK_CYCLES, '#' relocks early
// FAIL   | alarm for FAIL_CYCLES after a wrong attempt, keys ignored
// LOCKED | alarm for LOCKOUT_CYCLES after MAX_FAIL wrong attempts
// SET    | collecting a new password (PWD_CHANGE_EN builds only)
module locker_controller #(
    parameter logic [15:0] PASSWORD       = 16'h1234,
    parameter int unsigned UNLOCK_CYCLES  = 60_000_000,
    parameter int unsigned FAIL_CYCLES    = 12_000_000,
    parameter int unsigned LOCKOUT_CYCLES = 360_000_000,
    parameter int unsigned MAX_FAIL       = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_code,
    output logic        unlock,
    output logic        alarm,
    output logic [2:0]  state,
    output logic [2:0]  entry_cnt,
    output logic [15:0] entry_digits,
    output logic [2:0]  fail_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENTRY  = 3'd1,
        S_CHECK  = 3'd2,
        S_OPEN   = 3'd3,
        S_FAIL   = 3'd4,
        S_LOCKED = 3'd5,
        S_SET    = 3'd6
    } state_t;

    // Timers hold "cycles remaining minus one" so the terminal count is zero.
    localparam logic [31:0] UNLOCK_LOAD  = 32'(UNLOCK_CYCLES - 1);
    localparam logic [31:0] FAIL_LOAD    = 32'(FAIL_CYCLES - 1);
    localparam logic [31:0] LOCKOUT_LOAD = 32'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]  MAX_FAIL_3   = 3'(MAX_FAIL);

    state_t      state_q, state_d;
    logic [15:0] digits_q, digits_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  fail_q, fail_d;
    logic [31:0] timer_q, timer_d;
    logic [3:0]  prev_key_q;
    logic [15:0] password;

    logic key_event, is_digit, is_star, is_hash;
    logic digit_accept, timer_done, match;
    logic [15:0] digits_shift;

`ifdef PWD_CHANGE_EN
    logic [15:0] pwd_q, pwd_d;
    assign password = pwd_q;
`else
    assign password = PASSWORD;
`endif

    // A held key produces a single event; only a change away from the previous code counts.
    assign key_event    = (key_code != 4'hF) && (key_code != prev_key_q);
    assign is_digit     = key_event && (key_code <= 4'd9);
    assign is_star      = key_event && (key_code == 4'd10);
    assign is_hash      = key_event && (key_code == 4'd12);
    assign digit_accept = is_digit && (cnt_q < 3'd4);
    assign digits_shift = {digits_q[11:0], key_code};
    assign timer_done   = (timer_q == 32'd0);
    assign match        = (cnt_q == 3'd4) && (digits_q == password);

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        cnt_d    = cnt_q;
        fail_d   = fail_q;
        timer_d  = timer_q;
`ifdef PWD_CHANGE_EN
        pwd_d    = pwd_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (is_digit) begin
                    digits_d = {12'h000, key_code};
                    cnt_d    = 3'd1;
                    state_d  = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (digit_accept) begin
                    digits_d = digits_shift;
                    cnt_d    = cnt_q + 3'd1;
                end else if (is_star) begin
                    digits_d = 16'h0000;
                    cnt_d    = 3'd0;
                    state_d  = S_IDLE;
                end else if (is_hash) begin
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                digits_d = 16'h0000;
                cnt_d    = 3'd0;
                if (match) begin
                    fail_d  = 3'd0;
                    timer_d = UNLOCK_LOAD;
                    state_d = S_OPEN;
                end else if (fail_q + 3'd1 == MAX_FAIL_3) begin
                    fail_d  = 3'd0;
                    timer_d = LOCKOUT_LOAD;
                    state_d = S_LOCKED;
                end else begin
                    fail_d  = fail_q + 3'd1;
                    timer_d = FAIL_LOAD;
                    state_d = S_FAIL;
                end
            end
            S_OPEN: begin
                if (is_hash) begin
                    state_d = S_IDLE;
`ifdef PWD_CHANGE_EN
                end else if (is_star) begin
                    digits_d = 16'h0000;
                    cnt_d    = 3'd0;
                    state_d  = S_SET;
`endif
                end else if (timer_done) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            S_FAIL, S_LOCKED: begin
                if (timer_done) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
`ifdef PWD_CHANGE_EN
            S_SET: begin
                if (digit_accept) begin
                    digits_d = digits_shift;
                    cnt_d    = cnt_q + 3'd1;
                end else if (is_hash && (cnt_q == 3'd4)) begin
                    pwd_d    = digits_q;
                    digits_d = 16'h0000;
                    cnt_d    = 3'd0;
                    state_d  = S_IDLE;
                end else if (is_star) begin
                    digits_d = 16'h0000;
                    cnt_d    = 3'd0;
                    state_d  = S_IDLE;
                end
            end
`endif
            default: begin
                digits_d = 16'h0000;
                cnt_d    = 3'd0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            digits_q   <= 16'h0000;
            cnt_q      <= 3'd0;
            fail_q     <= 3'd0;
            timer_q    <= 32'd0;
            prev_key_q <= 4'hF;
`ifdef PWD_CHANGE_EN
            pwd_q      <= PASSWORD;
`endif
        end else begin
            state_q    <= state_d;
            digits_q   <= digits_d;
            cnt_q      <= cnt_d;
            fail_q     <= fail_d;
            timer_q    <= timer_d;
            prev_key_q <= key_code;
`ifdef PWD_CHANGE_EN
            pwd_q      <= pwd_d;
`endif
        end
    end

    assign unlock       = (state_q == S_OPEN);
    assign alarm        = (state_q == S_FAIL) || (state_q == S_LOCKED);
    assign state        = state_q;
    assign entry_cnt    = cnt_q;
    assign entry_digits = digits_q;
    assign fail_cnt     = fail_q;

endmodule
